// File: rtl/pc_exc_unit.sv
// pc_exc_unit: architectural PC and EPC registers with an exception-service FSM.
// Latency: a normal PC load shows one cycle after the edge; a handler PC shows at edge T+2+MEM_LAT.
// Backpressure: exc_busy stalls the control unit, and PC/exception inputs are ignored while it is high.
//
// Ports:
//   clk, reset            : rising-edge clock, synchronous active-high reset
//   pc_in                 : next-PC value from the PC-select mux
//   pc_write              : unconditional PC load
//   pc_write_cond         : branch load, taken when alu_zero ^ branch_ne
//   alu_zero, branch_ne   : branch condition inputs
//   exc_opcode/ovf/div0   : exception events, priority opcode > ovf > div0
//   mem_byte_in           : vector-table byte returned by memory
//   pc_out, epc_out       : current PC, and the saved PC fed back to the mux
//   exc_mem_addr          : vector address for the memory address mux
//   exc_mem_rd            : memory read request (REQ and WAIT states)
//   exc_busy              : exception sequence in progress
//   exc_cause             : latched cause code (1/2/3)
//
// Optional feature (macro PC_EXC_CAUSE_REG_EN): when it is defined, a cause
// register drives exc_cause. When it is undefined, exc_cause is tied to 0.
module pc_exc_unit #(
  parameter int               WIDTH      = 32,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int               MEM_LAT    = 2,
  parameter int               VEC_OPCODE = 253,
  parameter int               VEC_OVF    = 254,
  parameter int               VEC_DIV0   = 255
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pc_in,
  input  logic             pc_write,
  input  logic             pc_write_cond,
  input  logic             alu_zero,
  input  logic             branch_ne,
  input  logic             exc_opcode,
  input  logic             exc_ovf,
  input  logic             exc_div0,
  input  logic [7:0]       mem_byte_in,
  output logic [WIDTH-1:0] pc_out,
  output logic [WIDTH-1:0] epc_out,
  output logic [WIDTH-1:0] exc_mem_addr,
  output logic             exc_mem_rd,
  output logic             exc_busy,
  output logic [1:0]       exc_cause
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_WAIT = 2'd2;
  localparam logic [1:0] S_LOAD = 2'd3;

  // The counter only needs to hold MEM_LAT. Keep at least one bit so the
  // zero-latency build still has a legal vector.
  localparam int CW = (MEM_LAT > 1) ? $clog2(MEM_LAT + 1) : 1;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] pc_q;
  logic [WIDTH-1:0] epc_q;
  logic [WIDTH-1:0] vec_q;
  logic [WIDTH-1:0] vec_sel;
  logic             exc_any;
  logic             branch_take;

  assign exc_any     = exc_opcode | exc_ovf | exc_div0;
  assign branch_take = pc_write_cond & (alu_zero ^ branch_ne);

  always_comb begin
    vec_sel = WIDTH'(VEC_DIV0);
    if (exc_opcode)   vec_sel = WIDTH'(VEC_OPCODE);
    else if (exc_ovf) vec_sel = WIDTH'(VEC_OVF);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      cnt   <= '0;
      pc_q  <= RESET_PC;
      epc_q <= '0;
      vec_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          // An exception takes precedence over any PC write in the same cycle.
          if (exc_any) begin
            epc_q <= pc_q - WIDTH'(4);
            vec_q <= vec_sel;
            state <= S_REQ;
          end else if (pc_write || branch_take) begin
            pc_q <= pc_in;
          end
        end
        S_REQ: begin
          if (MEM_LAT > 0) begin
            cnt   <= CW'(MEM_LAT);
            state <= S_WAIT;
          end else begin
            state <= S_LOAD;
          end
        end
        S_WAIT: begin
          if (cnt == CW'(1)) state <= S_LOAD;
          else               cnt   <= cnt - CW'(1);
        end
        S_LOAD: begin
          pc_q  <= {{(WIDTH-8){1'b0}}, mem_byte_in};
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign pc_out       = pc_q;
  assign epc_out      = epc_q;
  assign exc_mem_addr = vec_q;
  assign exc_busy     = (state != S_IDLE);
  assign exc_mem_rd   = (state == S_REQ) || (state == S_WAIT);

`ifdef PC_EXC_CAUSE_REG_EN
  logic [1:0] cause_q;
  logic [1:0] cause_sel;

  always_comb begin
    cause_sel = 2'd3;
    if (exc_opcode)   cause_sel = 2'd1;
    else if (exc_ovf) cause_sel = 2'd2;
  end

  always_ff @(posedge clk) begin
    if (reset)                          cause_q <= 2'd0;
    else if (state == S_IDLE && exc_any) cause_q <= cause_sel;
  end

  assign exc_cause = cause_q;
`else
  assign exc_cause = 2'b00;
`endif

endmodule

// File: tb/tb_pc_exc_unit.sv
// tb_pc_exc_unit: directed-vector bench for pc_exc_unit.
// Instance u_dut uses MEM_LAT=2 and instance u_dut0 uses MEM_LAT=0. Both share every input except the exception lines.
// Inputs change 1 ns after a rising edge, and outputs are checked at that same point.
module tb_pc_exc_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_write, pc_write_cond, alu_zero, branch_ne;
  logic        exc_opcode, exc_ovf, exc_div0;
  logic        exc_opcode0, exc_ovf0, exc_div0_0;
  logic [7:0]  mem_byte_in;

  logic [31:0] pc_out, epc_out, exc_mem_addr;
  logic        exc_mem_rd, exc_busy;
  logic [1:0]  exc_cause;

  logic [31:0] pc_out0, epc_out0, exc_mem_addr0;
  logic        exc_mem_rd0, exc_busy0;
  logic [1:0]  exc_cause0;

  int passed = 0;
  int total  = 0;

`ifdef PC_EXC_CAUSE_REG_EN
  localparam logic [1:0] CAUSE_OVF    = 2'd2;
  localparam logic [1:0] CAUSE_OPCODE = 2'd1;
`else
  localparam logic [1:0] CAUSE_OVF    = 2'd0;
  localparam logic [1:0] CAUSE_OPCODE = 2'd0;
`endif

  always #5 clk = ~clk;

  pc_exc_unit #(.MEM_LAT(2)) u_dut (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .alu_zero(alu_zero), .branch_ne(branch_ne),
    .exc_opcode(exc_opcode), .exc_ovf(exc_ovf), .exc_div0(exc_div0),
    .mem_byte_in(mem_byte_in), .pc_out(pc_out), .epc_out(epc_out),
    .exc_mem_addr(exc_mem_addr), .exc_mem_rd(exc_mem_rd), .exc_busy(exc_busy),
    .exc_cause(exc_cause)
  );

  pc_exc_unit #(.MEM_LAT(0)) u_dut0 (
    .clk(clk), .reset(reset), .pc_in(pc_in), .pc_write(pc_write),
    .pc_write_cond(pc_write_cond), .alu_zero(alu_zero), .branch_ne(branch_ne),
    .exc_opcode(exc_opcode0), .exc_ovf(exc_ovf0), .exc_div0(exc_div0_0),
    .mem_byte_in(mem_byte_in), .pc_out(pc_out0), .epc_out(epc_out0),
    .exc_mem_addr(exc_mem_addr0), .exc_mem_rd(exc_mem_rd0), .exc_busy(exc_busy0),
    .exc_cause(exc_cause0)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  initial begin
    reset = 1'b1; pc_in = '0; pc_write = 0; pc_write_cond = 0; alu_zero = 0; branch_ne = 0;
    exc_opcode = 0; exc_ovf = 0; exc_div0 = 0;
    exc_opcode0 = 0; exc_ovf0 = 0; exc_div0_0 = 0; mem_byte_in = '0;
    tick(); tick();
    chk("rst_pc",    pc_out, 32'h0);
    chk("rst_epc",   epc_out, 32'h0);
    chk("rst_busy",  32'(exc_busy), 32'h0);
    chk("rst_rd",    32'(exc_mem_rd), 32'h0);
    chk("rst_addr",  exc_mem_addr, 32'h0);
    chk("rst_cause", 32'(exc_cause), 32'h0);

    // Unconditional write
    reset = 0; pc_in = 32'h4; pc_write = 1;
    tick(); pc_write = 0;
    chk("pcw_pc",   pc_out, 32'h4);
    chk("pcw_epc",  epc_out, 32'h0);
    chk("pcw_busy", 32'(exc_busy), 32'h0);

    // Branches: beq taken, beq not taken, bne taken
    pc_write_cond = 1; branch_ne = 0; alu_zero = 1; pc_in = 32'h40;
    tick(); chk("beq_taken", pc_out, 32'h40);
    pc_in = 32'h80; alu_zero = 0;
    tick(); chk("beq_hold", pc_out, 32'h40);
    branch_ne = 1; alu_zero = 0;
    tick(); chk("bne_taken", pc_out, 32'h80);
    pc_write_cond = 0; branch_ne = 0;

    // Overflow exception at PC 0x108. A pc_write in the same cycle loses.
    pc_in = 32'h108; pc_write = 1;
    tick(); chk("pc_108", pc_out, 32'h108);
    exc_ovf = 1; mem_byte_in = 8'h9C; pc_in = 32'h500;
    tick();                                   // edge T
    exc_ovf = 0;
    chk("ovf_epc",  epc_out, 32'h104);
    chk("ovf_pc",   pc_out, 32'h108);
    chk("ovf_rd0",  32'(exc_mem_rd), 32'h1);
    chk("ovf_addr", exc_mem_addr, 32'd254);
    chk("ovf_busy", 32'(exc_busy), 32'h1);
    exc_div0 = 1;                             // ignored while busy; pc_write still high
    tick();                                   // T+1
    chk("ovf_rd1",   32'(exc_mem_rd), 32'h1);
    chk("ovf_addr1", exc_mem_addr, 32'd254);
    chk("ovf_pc1",   pc_out, 32'h108);
    tick();                                   // T+2
    chk("ovf_rd2",   32'(exc_mem_rd), 32'h1);
    tick();                                   // T+3, LOAD
    exc_div0 = 0; pc_write = 0;
    chk("ovf_rd3",   32'(exc_mem_rd), 32'h0);
    chk("ovf_busy3", 32'(exc_busy), 32'h1);
    chk("ovf_epc3",  epc_out, 32'h104);
    tick();                                   // T+4
    chk("ovf_hpc",   pc_out, 32'h9C);
    chk("ovf_idle",  32'(exc_busy), 32'h0);
    chk("ovf_cause", 32'(exc_cause), 32'(CAUSE_OVF));

    // All causes at once from PC 0
    pc_in = 32'h0; pc_write = 1;
    tick(); pc_write = 0;
    chk("pc_zero", pc_out, 32'h0);
    exc_opcode = 1; exc_ovf = 1; exc_div0 = 1; mem_byte_in = 8'h33;
    tick();
    exc_opcode = 0; exc_ovf = 0; exc_div0 = 0;
    chk("all_epc",  epc_out, 32'hFFFF_FFFC);
    chk("all_addr", exc_mem_addr, 32'd253);
    tick();
    exc_div0 = 1;                             // nested attempt
    tick();
    exc_div0 = 0;
    tick();
    chk("nest_addr", exc_mem_addr, 32'd253);
    tick();
    chk("all_hpc",   pc_out, 32'h33);
    chk("nest_epc",  epc_out, 32'hFFFF_FFFC);
    chk("all_cause", 32'(exc_cause), 32'(CAUSE_OPCODE));
    tick();
    chk("nest_idle", 32'(exc_busy), 32'h0);

    // Reset during WAIT aborts the sequence
    pc_in = 32'h200; pc_write = 1;
    tick(); pc_write = 0;
    exc_div0 = 1; mem_byte_in = 8'h77;
    tick(); exc_div0 = 0;
    chk("div0_addr", exc_mem_addr, 32'd255);
    tick();                                   // now in WAIT
    reset = 1;
    tick(); reset = 0;
    chk("abort_pc",   pc_out, 32'h0);
    chk("abort_busy", 32'(exc_busy), 32'h0);
    chk("abort_rd",   32'(exc_mem_rd), 32'h0);
    chk("abort_epc",  epc_out, 32'h0);
    tick(); tick(); tick(); tick();
    chk("abort_noload", pc_out, 32'h0);
    chk("abort_idle",   32'(exc_busy), 32'h0);

    // Zero-latency instance: REQ at T+1, LOAD at T+2, handler after edge T+2
    chk("l0_pc_rst", pc_out0, 32'h0);
    exc_ovf0 = 1; mem_byte_in = 8'h5A;
    tick(); exc_ovf0 = 0;                     // edge T
    chk("l0_req_rd",   32'(exc_mem_rd0), 32'h1);
    chk("l0_req_addr", exc_mem_addr0, 32'd254);
    chk("l0_epc",      epc_out0, 32'hFFFF_FFFC);
    tick();                                   // edge T+1: LOAD
    chk("l0_load_rd",   32'(exc_mem_rd0), 32'h0);
    chk("l0_load_busy", 32'(exc_busy0), 32'h1);
    chk("l0_load_pc",   pc_out0, 32'h0);
    tick();                                   // edge T+2
    chk("l0_hpc",  pc_out0, 32'h5A);
    chk("l0_idle", 32'(exc_busy0), 32'h0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/pc_exc_unit.md
Name: pc_exc_unit

Overview:
- Downstream consumer of the PC-select multiplexer output.
- Holds the architectural PC register and the EPC register; EPC feeds back into the mux's EPC input.
- Runs a small FSM that services exceptions: captures EPC, reads the handler-address byte from the vector table in memory, and loads the zero-extended byte into PC.
- Sits between the PC-select mux, the control unit and the memory address path of the multicycle CPU.

Parameters:
- WIDTH, 32, datapath width of PC/EPC
- RESET_PC, 32'h0000_0000, PC value after reset
- MEM_LAT, 2, extra wait cycles before memory byte is valid (0 allowed)
- VEC_OPCODE, 253, vector-table byte address for invalid opcode
- VEC_OVF, 254, vector-table byte address for arithmetic overflow
- VEC_DIV0, 255, vector-table byte address for divide by zero

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- pc_in  in  WIDTH  next-PC value from PC-select mux
- pc_write  in  1  unconditional PC load
- pc_write_cond  in  1  conditional PC load (branch)
- alu_zero  in  1  ALU zero flag
- branch_ne  in  1  1 = branch when !alu_zero (bne), 0 = when alu_zero (beq)
- exc_opcode  in  1  invalid-opcode event
- exc_ovf  in  1  overflow event
- exc_div0  in  1  divide-by-zero event
- mem_byte_in  in  8  byte returned by memory
- pc_out  out  WIDTH  current PC
- epc_out  out  WIDTH  EPC, to mux EPC input
- exc_mem_addr  out  WIDTH  vector address driven to memory address mux
- exc_mem_rd  out  1  memory read request owned by this block
- exc_busy  out  1  exception sequence in progress; control unit must stall
- exc_cause  out  2  latched cause (see Optional Feature)

Behaviour:
- Reset (sync, clk edge with reset=1):
  - pc_out = RESET_PC; epc_out = 0; exc_cause = 0.
  - FSM -> IDLE; exc_mem_rd = 0; exc_busy = 0; exc_mem_addr = 0.
  - Reset mid-sequence aborts the sequence; no PC load from memory occurs.
- Normal PC update (FSM in IDLE, no exception this cycle):
  - PC <= pc_in if pc_write = 1.
  - Else PC <= pc_in if pc_write_cond = 1 and (alu_zero XOR branch_ne) = 1.
  - Else PC holds.
  - Update visible the cycle after the edge.
- Exception entry (IDLE, any exc_* = 1 at the edge):
  - EPC <= pc_out - 4, modulo 2^WIDTH; PC 0 gives 32'hFFFF_FFFC.
  - Cause priority: opcode (code 1) > ovf (code 2) > div0 (code 3). Vector selected accordingly and latched.
  - PC writes in that cycle are suppressed.
  - FSM -> REQ.
- FSM states:
  - IDLE: exc_busy = 0; exc_mem_rd = 0.
  - REQ (1 cycle): exc_busy = 1; exc_mem_rd = 1; exc_mem_addr = vector. Next state is WAIT if MEM_LAT > 0, else LOAD. Wait counter loaded with MEM_LAT.
  - WAIT (MEM_LAT cycles): exc_busy = 1; exc_mem_rd = 1; address held; counter decrements; -> LOAD when counter reaches 1.
  - LOAD (1 cycle): exc_busy = 1; exc_mem_rd = 0. PC <= {zeros, mem_byte_in} at the edge; -> IDLE.
- Latency: exception sampled at edge T gives PC = handler at edge T + 2 + MEM_LAT.
- While exc_busy = 1:
  - pc_write, pc_write_cond and all exc_* inputs are ignored. No nesting; EPC is not overwritten.
- Exception and pc_write asserted in the same IDLE cycle: exception wins; PC unchanged; EPC uses the pre-edge pc_out.
- EPC changes only on exception entry or reset.

Optional Feature:
- Macro: PC_EXC_CAUSE_REG_EN
- Defined:
  - exc_cause holds the latched 2-bit cause code from exception entry until the next exception entry or reset.
  - Reset value 0; value persists after return to IDLE.
- Undefined:
  - No cause register is synthesised; exc_cause is tied to 2'b00.
  - Vector selection is still latched internally for the duration of the sequence.

Test Plan:
- Reset, then pc_in = 32'h0000_0004, pc_write = 1 for one cycle -> pc_out = 0x4 next cycle; epc_out = 0; exc_busy = 0.
- pc_write_cond = 1, branch_ne = 0, alu_zero = 1, pc_in = 0x40 -> pc_out = 0x40. Repeat with alu_zero = 0 -> PC holds. Repeat with branch_ne = 1, alu_zero = 0 -> loads.
- pc_out = 0x108, exc_ovf = 1, MEM_LAT = 2, mem_byte_in = 8'h9C:
  - epc_out = 0x104.
  - exc_mem_addr = 254 with exc_mem_rd = 1 for 3 cycles.
  - pc_out = 0x9C at edge T+4.
  - exc_cause = 2 (feature on).
- exc_opcode, exc_ovf and exc_div0 all asserted with pc_out = 0 -> vector 253; epc_out = 0xFFFF_FFFC; exc_cause = 1. A second exc_div0 during busy is ignored; epc_out stays unchanged.
- Reset asserted during WAIT -> pc_out = RESET_PC; FSM IDLE; exc_mem_rd = 0 next cycle; no later handler load.
- MEM_LAT = 0 build: exception at T -> REQ at T+1, LOAD at T+2, handler PC visible after edge T+2.
